// File: rtl/wb_queue.sv
// Write-back queue feeding the 8 x 16-bit register file write port.
// Buffers write requests in order, drains one per cycle, and forwards pending data to decode.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_W-1:0]         in_dr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [REG_W-1:0]         rf_dr,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [REG_W-1:0]         sr1,
  input  logic [REG_W-1:0]         sr2,
  output logic                     sr1_hit,
  output logic [DATA_W-1:0]        sr1_fwd,
  output logic                     sr2_hit,
  output logic [DATA_W-1:0]        sr2_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_W-1:0]  dr_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;
  logic              not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign rf_we     = drain_en && not_empty;
  assign pop       = rf_we;
  assign rf_dr     = not_empty ? dr_mem[head]   : '0;
  assign rf_data   = not_empty ? data_mem[head] : '0;

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PTR_W'(1);
      end
      // Push and pop never target the same slot: that would need count at 0 and DEPTH at once.
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload is not reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      dr_mem[tail]   <= in_dr;
      data_mem[tail] <= in_data;
    end
  end

  // Walk from head to tail so the youngest matching entry overrides older ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    sr1_hit = 1'b0;
    sr1_fwd = '0;
    sr2_hit = 1'b0;
    sr2_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (vld[idx] && (dr_mem[idx] == sr1)) begin
        sr1_hit = 1'b1;
        sr1_fwd = data_mem[idx];
      end
      if (vld[idx] && (dr_mem[idx] == sr2)) begin
        sr2_hit = 1'b1;
        sr2_fwd = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenario tasks plus a scoreboard that tracks
// accepted requests and checks every register-file write against accept order.
module tb_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_dr;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic              rf_we;
  logic [REG_W-1:0]  rf_dr;
  logic [DATA_W-1:0] rf_data;
  logic [REG_W-1:0]  sr1;
  logic [REG_W-1:0]  sr2;
  logic              sr1_hit;
  logic [DATA_W-1:0] sr1_fwd;
  logic              sr2_hit;
  logic [DATA_W-1:0] sr2_fwd;
  logic [2:0]        count;

  int n_cmp;
  int n_err;
  int n_pops;

  logic [REG_W+DATA_W-1:0] exp_q [$];

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dr(in_dr), .in_data(in_data),
    .drain_en(drain_en),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data),
    .sr1(sr1), .sr2(sr2),
    .sr1_hit(sr1_hit), .sr1_fwd(sr1_fwd), .sr2_hit(sr2_hit), .sr2_fwd(sr2_fwd),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    logic [REG_W+DATA_W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rf_we) begin
        n_pops++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rf_unexpected: got dr=%0d data=%h, want no write", rf_dr, rf_data);
        end else begin
          e = exp_q.pop_front();
          if ({rf_dr, rf_data} !== e) begin
            n_err++;
            $display("FAIL rf_order: got dr=%0d data=%h, want dr=%0d data=%h",
                     rf_dr, rf_data, e[REG_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_dr, in_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 20 && count != 3'd0; k++) tick();
    n_cmp++;
    if (count !== 3'd0) begin
      n_err++;
      $display("FAIL %s_drain_timeout: got count=%0d, want 0", name, count);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_sb_left: got %0d pending, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; drain_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, want 1", in_ready); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d, want 0", count); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b, want 0", rf_we); end
    n_cmp++; if ({rf_dr, rf_data} !== '0) begin n_err++; $display("FAIL reset_rf_bus: got %h/%h, want 0/0", rf_dr, rf_data); end
    n_cmp++; if ({sr1_hit, sr2_hit} !== 2'b00) begin n_err++; $display("FAIL reset_hits: got %b%b, want 00", sr1_hit, sr2_hit); end
    n_cmp++; if ({sr1_fwd, sr2_fwd} !== '0) begin n_err++; $display("FAIL reset_fwd: got %h/%h, want 0/0", sr1_fwd, sr2_fwd); end
  endtask

  task automatic test_single();
    drain_en = 1'b1; in_valid = 1'b1; in_dr = 3'd3; in_data = 16'h1234; sr1 = 3'd3;
    #1;
    n_cmp++; if ({rf_we, sr1_hit} !== 2'b00) begin n_err++; $display("FAIL single_bypass: got we=%b hit=%b, want 0 0", rf_we, sr1_hit); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if ({rf_we, rf_dr, rf_data} !== {1'b1, 3'd3, 16'h1234}) begin
      n_err++; $display("FAIL single_rf: got we=%b dr=%0d data=%h, want 1 3 1234", rf_we, rf_dr, rf_data);
    end
    n_cmp++; if ({sr1_hit, sr1_fwd} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL single_fwd: got hit=%b fwd=%h, want 1 1234", sr1_hit, sr1_fwd);
    end
    tick();
    n_cmp++; if ({count, sr1_hit} !== {3'd0, 1'b0}) begin
      n_err++; $display("FAIL single_after: got count=%0d hit=%b, want 0 0", count, sr1_hit);
    end
  endtask

  task automatic test_fill();
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dr = 3'(i); in_data = 16'h0100 + 16'(i);
      tick();
    end
    in_dr = 3'd4; in_data = 16'h0104;
    #1;
    n_cmp++; if ({count, in_ready} !== {3'd4, 1'b0}) begin
      n_err++; $display("FAIL fill_full: got count=%0d ready=%b, want 4 0", count, in_ready);
    end
    n_cmp++; if ({rf_we, rf_dr, rf_data} !== {1'b0, 3'd0, 16'h0100}) begin
      n_err++; $display("FAIL fill_head: got we=%b dr=%0d data=%h, want 0 0 0100", rf_we, rf_dr, rf_data);
    end
    tick();
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_hold: got count=%0d, want 4", count); end
    drain_en = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_drain: got %b, want 0", in_ready); end
    tick();
    n_cmp++; if ({count, in_ready} !== {3'd3, 1'b1}) begin
      n_err++; $display("FAIL fill_reopen: got count=%0d ready=%b, want 3 1", count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL fill_pushpop: got count=%0d, want 3", count); end
    wait_empty("fill");
  endtask

  task automatic test_youngest();
    logic [REG_W+DATA_W-1:0] reqs [3];
    reqs[0] = {3'd5, 16'h00AA};
    reqs[1] = {3'd5, 16'h00BB};
    reqs[2] = {3'd2, 16'h0011};
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; {in_dr, in_data} = reqs[i];
      tick();
    end
    in_valid = 1'b0; sr1 = 3'd5; sr2 = 3'd2;
    #1;
    n_cmp++; if ({sr1_hit, sr1_fwd} !== {1'b1, 16'h00BB}) begin
      n_err++; $display("FAIL young_sr1: got hit=%b fwd=%h, want 1 00bb", sr1_hit, sr1_fwd);
    end
    n_cmp++; if ({sr2_hit, sr2_fwd} !== {1'b1, 16'h0011}) begin
      n_err++; $display("FAIL young_sr2: got hit=%b fwd=%h, want 1 0011", sr2_hit, sr2_fwd);
    end
    sr1 = 3'd7; in_valid = 1'b1; in_dr = 3'd7; in_data = 16'h0077;
    #1;
    n_cmp++; if ({sr1_hit, sr1_fwd} !== {1'b0, 16'h0000}) begin
      n_err++; $display("FAIL young_miss: got hit=%b fwd=%h, want 0 0000", sr1_hit, sr1_fwd);
    end
    in_valid = 1'b0; sr1 = 3'd5; drain_en = 1'b1;
    tick();
    n_cmp++; if ({sr1_hit, sr1_fwd} !== {1'b1, 16'h00BB}) begin
      n_err++; $display("FAIL young_after_pop: got hit=%b fwd=%h, want 1 00bb", sr1_hit, sr1_fwd);
    end
    wait_empty("young");
  endtask

  task automatic test_back_to_back();
    int pops0;
    pops0 = n_pops;
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_dr = 3'(i % 8); in_data = 16'(i);
      tick();
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count_%0d: got %0d, want 1", i, count); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_final: got count=%0d, want 0", count); end
    n_cmp++; if (n_pops - pops0 != 10) begin n_err++; $display("FAIL b2b_writes: got %0d, want 10", n_pops - pops0); end
  endtask

  task automatic test_mid_reset();
    int pops0;
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dr = 3'(i + 1); in_data = 16'hC000 + 16'(i);
      tick();
    end
    in_valid = 1'b0; sr1 = 3'd2; sr2 = 3'd3;
    #1;
    n_cmp++; if ({count, sr1_hit} !== {3'd3, 1'b1}) begin
      n_err++; $display("FAIL mid_pending: got count=%0d hit=%b, want 3 1", count, sr1_hit);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; drain_en = 1'b1;
    pops0 = n_pops;
    #1;
    n_cmp++; if ({count, rf_we, sr1_hit, sr2_hit} !== {3'd0, 3'b000}) begin
      n_err++; $display("FAIL mid_cleared: got count=%0d we=%b hits=%b%b, want 0 0 00", count, rf_we, sr1_hit, sr2_hit);
    end
    tick(); tick(); tick();
    n_cmp++; if (n_pops != pops0) begin n_err++; $display("FAIL mid_no_writes: got %0d writes, want 0", n_pops - pops0); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_pops = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_dr = '0; in_data = '0;
    drain_en = 1'b0; sr1 = '0; sr2 = '0;
    test_reset();
    test_single();
    test_fill();
    test_youngest();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
Write-back queue on the writer side of the 8 x 16-bit register file (R0-R7; asynchronous reads, synchronous writes).
- Accepts register write requests (dest, data) from the pipeline's write-back stage through a valid/ready handshake.
- Buffers them in order and drains one per cycle into the register file's write port (we/dr/data_in).
- Provides two forwarding lookups so decode-stage readers see pending, not-yet-written values.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
DATA_W, 16, register data width
REG_W, 3, register index width (8 registers)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  write request valid
in_ready  output  1  queue can accept a request this cycle
in_dr  input  REG_W  destination register of request
in_data  input  DATA_W  data of request
drain_en  input  1  permits draining the head entry this cycle
rf_we  output  1  register-file write enable
rf_dr  output  REG_W  register-file destination
rf_data  output  DATA_W  register-file write data
sr1  input  REG_W  source register 1 being read by decode
sr2  input  REG_W  source register 2 being read by decode
sr1_hit  output  1  sr1 has a pending write in queue
sr1_fwd  output  DATA_W  youngest pending data for sr1
sr2_hit  output  1  sr2 has a pending write in queue
sr2_fwd  output  DATA_W  youngest pending data for sr2
count  output  log2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: DEPTH-entry circular buffer; head (read) and tail (write) pointers wrap modulo DEPTH; per-entry valid bit.
- Reset (rst_n=0 at rising edge): pointers=0, count=0, all valid bits cleared.
  - Outputs after reset: in_ready=1, rf_we=0, rf_dr=0, rf_data=0, sr*_hit=0, sr*_fwd=0.
  - Reset mid-operation discards all pending writes; none reach the register file.
- Enqueue: when in_valid && in_ready at a rising edge, write {in_dr, in_data} at tail, set valid, tail+1.
  - in_ready = (count < DEPTH), combinational from registered state only.
  - A drain in the same cycle does not make a full queue ready.
  - in_valid while in_ready=0: request not taken; requester must hold it.
- Drain: combinational rf_we = drain_en && (count != 0).
  - rf_dr/rf_data present the head entry whenever count != 0; 0 when empty.
  - When rf_we=1, the head is popped at the same rising edge the register file captures the write (head+1, valid cleared).
- Latency: a request accepted at edge N is visible on rf_* during cycle N..N+1 (if at head and drain_en=1) and written into the register file at edge N+1. Minimum 1 cycle; no same-cycle bypass of in_* to rf_*.
- Count: +1 on enqueue only, -1 on drain only, unchanged on both or neither. Range 0..DEPTH.
- Simultaneous enqueue + drain when 0 < count < DEPTH: both occur and count is unchanged; ordering is preserved.
- Empty: no drain, rf_we=0 regardless of drain_en; an enqueue occurs normally.
- Forwarding (combinational, per port independently):
  - hit=1 if any valid entry has dr == sr; fwd = data of the youngest such entry (closest to tail); the head entry is included.
  - In-flight in_* requests not yet accepted are not searched.
  - No hit: hit=0, fwd=0.
  - Consumer uses hit ? fwd : regfile read data.
- Duplicate destinations are allowed. Entries drain in order, so the register file ends holding the youngest value.
- Handshake/order invariant: the register-file write order equals the accept order exactly.

Test Plan:
- Reset then idle: rst_n=0 one edge -> in_ready=1, count=0, rf_we=0, sr1_hit=sr2_hit=0, fwd=0.
- Single write: drain_en=1; accept {dr=3,data=0x1234} at edge N -> during the next cycle rf_we=1, rf_dr=3, rf_data=0x1234, sr1=3 gives sr1_hit=1/sr1_fwd=0x1234; after edge N+1 count=0, hit=0.
- Fill/backpressure: drain_en=0; enqueue 4 writes -> count=4, in_ready=0. A 5th request held with in_valid=1 is not taken. Set drain_en=1 -> writes emerge in order, and the 5th is accepted on the first cycle in_ready returns to 1.
- Youngest forwarding: drain_en=0; enqueue {5,0x00AA}, {5,0x00BB}, {2,0x0011} -> sr1=5 gives fwd=0x00BB, sr2=2 gives fwd=0x0011, sr1=7 gives hit=0. Drain all -> rf sees 0x00AA, then 0x00BB for R5.
- Simultaneous push/pop with pointer wrap: continuous in_valid and drain_en=1 for 10 cycles with incrementing data 0..9 -> count stays 1, rf_data sequence 0..9 with no gaps or duplicates.
- Reset mid-operation: 3 entries pending, rst_n=0 one edge -> count=0, rf_we=0 the following cycle, hits cleared, no further writes emitted.
